// File: rtl/accel_host_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | accel_host_driver_pkg: shared FSM states and constants.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package accel_host_driver_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_X_IN       = 768;

  // Accelerator X buffer; weight buffers are never selected by this driver.
  localparam logic [2:0] MEM_SEL_X = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ARM      = 3'd2,
    S_START    = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_CAPTURE  = 3'd5,
    S_HOLD     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/accel_host_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | accel_host_driver_if: host vector/result handshake + accel bus.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface accel_host_driver_if
  import accel_host_driver_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int X_IN        = DEFAULT_X_IN,
  parameter int WORD_ADDR_W = 12
);

  logic                         vec_valid;
  logic [X_IN*DATA_WIDTH-1:0]   vec_in;
  logic                         vec_ready;
  logic                         res_valid;
  logic [X_IN*DATA_WIDTH-1:0]   res_out;
  logic                         res_ready;

  logic [WORD_ADDR_W-1:0]       wrd_addr;
  logic [DATA_WIDTH-1:0]        data_in;
  logic [2:0]                   mem_sel;
  logic                         start;
  logic                         input_rdy;
  logic                         output_rdy;
  logic [DATA_WIDTH-1:0]        data_out;

  // The driver is the master of both the result path and the accelerator bus.
  modport master (
    input  vec_valid, vec_in, res_ready, input_rdy, output_rdy, data_out,
    output vec_ready, res_valid, res_out, wrd_addr, data_in, mem_sel, start
  );

  modport slave (
    output vec_valid, vec_in, res_ready, input_rdy, output_rdy, data_out,
    input  vec_ready, res_valid, res_out, wrd_addr, data_in, mem_sel, start
  );

endinterface
`default_nettype wire

// File: rtl/accel_host_driver_word_shift_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | word_shift_capture: X_IN-word serial-to-parallel result register.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module word_shift_capture #(
  parameter int DATA_WIDTH = 4,
  parameter int X_IN       = 768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [X_IN*DATA_WIDTH-1:0] vec
);

  localparam int VEC_W = X_IN * DATA_WIDTH;

  // Words enter at the top and move down, so the first word lands in word 0.
  generate
    if (X_IN == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          vec <= '0;
        end else if (shift_en) begin
          vec <= din;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          vec <= '0;
        end else if (shift_en) begin
          vec <= {din, vec[VEC_W-1:DATA_WIDTH]};
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/accel_host_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | accel_host_driver: loads a vector into the accelerator, starts it, |
// | deserialises the result and hands it to the host. Rev 1.0          |
// +--------------------------------------------------------------------+
module accel_host_driver
  import accel_host_driver_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int X_IN          = DEFAULT_X_IN,
  parameter int WORD_ADDR_W   = 12,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  accel_host_driver_if.master  bus
);

  localparam int IDX_W = (X_IN > 1) ? $clog2(X_IN) : 1;
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(X_IN - 1);

  // All-ones must lie outside the buffer, so the idle address never writes.
  generate
    if (longint'(X_IN) >= (longint'(1) << WORD_ADDR_W)) begin : g_addr_too_narrow
      $error("X_IN must be smaller than 2**WORD_ADDR_W");
    end
    if (longint'(X_IN) >= (longint'(1) << COUNTER_WIDTH)) begin : g_cnt_too_narrow
      $error("X_IN must be smaller than 2**COUNTER_WIDTH");
    end
  endgenerate

  state_t                         state;
  logic [COUNTER_WIDTH-1:0]       cnt;
  logic [COUNTER_WIDTH-1:0]       cnt_next;
  logic [DATA_WIDTH-1:0]          shadow [X_IN];
  logic [X_IN*DATA_WIDTH-1:0]     captured;
  logic                           capture_en;
  logic                           accept;

  assign cnt_next    = cnt + COUNTER_WIDTH'(1);
  assign capture_en  = (state == S_CAPTURE);
  assign accept      = bus.vec_ready && bus.vec_valid;
  assign bus.mem_sel = MEM_SEL_X;
  assign bus.res_out = captured;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < X_IN; k++) shadow[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < X_IN; k++) shadow[k] <= bus.vec_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are registered alongside the state, so each one is set on the
  // transition into the state whose value it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.vec_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.start     <= 1'b0;
      bus.wrd_addr  <= '1;
      bus.data_in   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.vec_valid) begin
            state         <= S_LOAD;
            cnt           <= '0;
            bus.vec_ready <= 1'b0;
            bus.wrd_addr  <= '0;
            bus.data_in   <= bus.vec_in[DATA_WIDTH-1:0];
          end
        end
        S_LOAD: begin
          if (cnt == LAST) begin
            state        <= S_ARM;
            bus.wrd_addr <= '1;
            bus.data_in  <= '0;
          end else begin
            cnt          <= cnt_next;
            bus.wrd_addr <= WORD_ADDR_W'(cnt_next);
            bus.data_in  <= shadow[cnt_next[IDX_W-1:0]];
          end
        end
        S_ARM: begin
          if (bus.input_rdy) begin
            state     <= S_START;
            bus.start <= 1'b1;
          end
        end
        S_START: begin
          state     <= S_WAIT_OUT;
          bus.start <= 1'b0;
        end
        S_WAIT_OUT: begin
          if (bus.output_rdy) begin
            state <= S_CAPTURE;
            cnt   <= '0;
          end
        end
        S_CAPTURE: begin
          if (cnt == LAST) begin
            state         <= S_HOLD;
            bus.res_valid <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            state         <= S_IDLE;
            bus.res_valid <= 1'b0;
            bus.vec_ready <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.vec_ready <= 1'b1;
          bus.res_valid <= 1'b0;
          bus.start     <= 1'b0;
          bus.wrd_addr  <= '1;
          bus.data_in   <= '0;
        end
      endcase
    end
  end

  word_shift_capture #(
    .DATA_WIDTH (DATA_WIDTH),
    .X_IN       (X_IN)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .shift_en (capture_en),
    .din      (bus.data_out),
    .vec      (captured)
  );

endmodule
`default_nettype wire

// File: tb/tb_accel_host_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_accel_host_driver: randomised bench with a transaction model.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_accel_host_driver;

  localparam int DW = 4;
  localparam int XN = 8;
  localparam int AW = 12;
  localparam int VW = DW * XN;

  logic clk;
  logic rst;

  accel_host_driver_if #(.DATA_WIDTH(DW), .X_IN(XN), .WORD_ADDR_W(AW)) bus ();

  accel_host_driver #(
    .DATA_WIDTH    (DW),
    .X_IN          (XN),
    .WORD_ADDR_W   (AW),
    .COUNTER_WIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  logic          irdy_low  = 1'b0;
  logic          spurious  = 1'b0;
  logic          resp_mode = 1'b0;
  logic [DW-1:0] resp [XN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accelerator stand-in: random input_rdy, random latency after start,
  // one output_rdy cycle, then XN result words on consecutive cycles.
  initial begin : accel_model
    int wait_left;
    int word_idx;
    wait_left = -1;
    word_idx  = -1;
    bus.input_rdy  = 1'b0;
    bus.output_rdy = 1'b0;
    bus.data_out   = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.input_rdy  = irdy_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.data_out   = DW'($urandom);
      bus.output_rdy = spurious;
      if (word_idx >= 0) begin
        bus.data_out   = resp[word_idx];
        bus.output_rdy = ($urandom_range(0, 1) == 1);
        word_idx++;
        if (word_idx == XN) word_idx = -1;
      end else if (wait_left == 0) begin
        bus.output_rdy = 1'b1;
        word_idx  = 0;
        wait_left = -1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (bus.start) begin
        wait_left = $urandom_range(0, 4);
        for (int k = 0; k < XN; k++)
          resp[k] = resp_mode ? DW'($urandom) : DW'(XN - 1 - k);
      end
      if (rst) begin
        wait_left = -1;
        word_idx  = -1;
      end
    end
  end

  // Transaction-level reference: a phase label, the words still to be
  // written, and the words collected so far.
  localparam int M_IDLE = 0, M_LOAD = 1, M_ARM = 2, M_START = 3,
                 M_WAIT = 4, M_CAP = 5, M_HOLD = 6;
  int            m_phase = M_IDLE;
  int            m_idx   = 0;
  logic          model_on = 1'b0;
  logic [DW-1:0] m_words [$];
  logic [DW-1:0] m_cap   [$];
  logic [VW-1:0] m_res   = '0;

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt++;
    if (model_on) begin
      check("vec_ready", 64'(bus.vec_ready), 64'(m_phase == M_IDLE));
      check("res_valid", 64'(bus.res_valid), 64'(m_phase == M_HOLD));
      check("start",     64'(bus.start),     64'(m_phase == M_START));
      check("mem_sel",   64'(bus.mem_sel),   64'(3'd6));
      check("wrd_addr",  64'(bus.wrd_addr),
            (m_phase == M_LOAD) ? 64'(m_idx) : 64'({AW{1'b1}}));
      check("data_in",   64'(bus.data_in),
            (m_phase == M_LOAD) ? 64'(m_words[m_idx]) : 64'(0));
      if (m_phase == M_HOLD) check("res_out", 64'(bus.res_out), 64'(m_res));
    end
    if (rst) begin
      model_on = 1'b1;
      m_phase  = M_IDLE;
      m_res    = '0;
      m_words.delete();
      m_cap.delete();
    end else if (model_on) begin
      case (m_phase)
        M_IDLE: if (bus.vec_valid) begin
          m_words.delete();
          for (int k = 0; k < XN; k++) m_words.push_back(bus.vec_in[k*DW +: DW]);
          m_idx   = 0;
          m_phase = M_LOAD;
        end
        M_LOAD: begin
          m_idx++;
          if (m_idx == XN) m_phase = M_ARM;
        end
        M_ARM:   if (bus.input_rdy) m_phase = M_START;
        M_START: m_phase = M_WAIT;
        M_WAIT:  if (bus.output_rdy) begin
          m_cap.delete();
          m_phase = M_CAP;
        end
        M_CAP: begin
          m_cap.push_back(bus.data_out);
          if (m_cap.size() == XN) begin
            for (int k = 0; k < XN; k++) m_res[k*DW +: DW] = m_cap[k];
            m_phase = M_HOLD;
          end
        end
        M_HOLD:  if (bus.res_ready) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [VW-1:0] vec1, vec2, held, exp_rev, exp2;
    logic          got;
    int            base, rst_at;
    logic          done;

    rst = 1'b1;
    bus.vec_valid = 1'b0;
    bus.vec_in    = '0;
    bus.res_ready = 1'b0;
    repeat (3) step();
    check("rst_vec_ready", 64'(bus.vec_ready), 64'(1));
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_start",     64'(bus.start),     64'(0));
    check("rst_wrd_addr",  64'(bus.wrd_addr),  64'(12'hFFF));
    check("rst_data_in",   64'(bus.data_in),   64'(0));
    check("rst_mem_sel",   64'(bus.mem_sel),   64'(6));
    check("rst_res_out",   64'(bus.res_out),   64'(0));
    rst = 1'b0;

    // Vector k = k, input_rdy withheld for 20 cycles after the load.
    irdy_low  = 1'b1;
    resp_mode = 1'b0;
    for (int k = 0; k < XN; k++) vec1[k*DW +: DW] = DW'(k % 16);
    bus.vec_in    = vec1;
    bus.vec_valid = 1'b1;
    step();
    bus.vec_valid = 1'b0;
    for (int k = 0; k < XN; k++) begin
      check($sformatf("load_addr%0d", k), 64'(bus.wrd_addr), 64'(k));
      check($sformatf("load_data%0d", k), 64'(bus.data_in),  64'(k));
      step();
    end
    check("load_end_addr", 64'(bus.wrd_addr), 64'(12'hFFF));
    base = start_cnt;
    repeat (20) step();
    check("no_start_while_busy", 64'(start_cnt - base), 64'(0));
    irdy_low = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.start) got = 1'b1;
      else step();
    end
    check("start_seen", 64'(got), 64'(1));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.res_valid) got = 1'b1;
      else step();
    end
    check("result_seen", 64'(got), 64'(1));
    check("one_start_pulse", 64'(start_cnt - base), 64'(1));
    for (int k = 0; k < XN; k++) exp_rev[k*DW +: DW] = DW'(XN - 1 - k);
    check("res_word0", 64'(bus.res_out[3:0]),   64'(7));
    check("res_word7", 64'(bus.res_out[31:28]), 64'(0));
    check("res_reverse", 64'(bus.res_out), 64'(exp_rev));

    // Result left unconsumed while a second vector is already offered.
    resp_mode = 1'b1;
    vec2 = VW'($urandom);
    bus.vec_in    = vec2;
    bus.vec_valid = 1'b1;
    held = bus.res_out;
    base = 0;
    repeat (50) begin
      if (bus.vec_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_out !== held) base++;
      step();
    end
    check("hold_stall_cycles_bad", 64'(base), 64'(0));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("after_hs_res_valid", 64'(bus.res_valid), 64'(0));
    check("after_hs_vec_ready", 64'(bus.vec_ready), 64'(1));
    step();
    bus.vec_valid = 1'b0;
    spurious = 1'b1;
    check("vec2_addr0", 64'(bus.wrd_addr), 64'(0));
    check("vec2_data0", 64'(bus.data_in),  64'(vec2[DW-1:0]));
    step();
    spurious = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      if (bus.res_valid) got = 1'b1;
      else step();
    end
    check("result2_seen", 64'(got), 64'(1));
    for (int k = 0; k < XN; k++) exp2[k*DW +: DW] = resp[k];
    check("result2_value", 64'(bus.res_out), 64'(exp2));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Reset while word 4 is on the accelerator bus.
    bus.vec_in    = VW'($urandom);
    bus.vec_valid = 1'b1;
    step();
    bus.vec_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.wrd_addr == 12'd4) got = 1'b1;
      else step();
    end
    check("reached_word4", 64'(got), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_vec_ready", 64'(bus.vec_ready), 64'(1));
    check("abort_wrd_addr",  64'(bus.wrd_addr),  64'(12'hFFF));
    check("abort_start",     64'(bus.start),     64'(0));
    base = start_cnt;
    repeat (30) step();
    check("abort_no_start", 64'(start_cnt - base), 64'(0));
    check("abort_no_result", 64'(bus.res_valid), 64'(0));

    // Random traffic, occasionally cut short by a reset.
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 3)) step();
      for (int k = 0; k < XN; k++) bus.vec_in[k*DW +: DW] = DW'($urandom);
      bus.vec_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        if (bus.vec_ready) got = 1'b1;
        else step();
      end
      check("accept_in_time", 64'(got), 64'(1));
      step();
      bus.vec_valid = 1'b0;
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : -1;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        if (c == rst_at) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          done = 1'b1;
        end else begin
          bus.res_ready = ($urandom_range(0, 2) == 0);
          if (bus.res_valid && bus.res_ready) done = 1'b1;
          step();
        end
      end
      bus.res_ready = 1'b0;
      check("txn_done_in_time", 64'(done), 64'(1));
    end

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
